// File: rtl/eh2_pkg.sv
// Shared types and SECDED(39,32) helpers for the LSU DCCM read-modify-write path.
package eh2_pkg;

  typedef enum logic [1:0] {
    RMW_IDLE = 2'd0,
    RMW_RD   = 2'd1,
    RMW_WAIT = 2'd2,
    RMW_WR   = 2'd3
  } rmw_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        sb_err;
    logic        db_err;
  } ecc_dec_t;

  // Column j of these masks is the Hamming codeword position of data bit j.
  localparam logic [5:0][31:0] ECC_MASK = {
    32'hFC000000, 32'h03FFF800, 32'h03FC07F0,
    32'hE3C3C78E, 32'h9B33366D, 32'h56AAAD5B
  };

  function automatic logic [6:0] rvecc_encode(input logic [31:0] din);
    logic [6:0] ecc;
    ecc = 7'd0;
    for (int i = 0; i < 6; i++) begin
      ecc[i] = ^(din & ECC_MASK[i]);
    end
    ecc[6] = ^{din, ecc[5:0]};
    return ecc;
  endfunction

  function automatic ecc_dec_t rvecc_decode(input logic [38:0] fdata);
    logic [31:0] din;
    logic [6:0]  chk;
    logic [5:0]  pos;
    ecc_dec_t    res;
    din = fdata[31:0];
    chk = 7'd0;
    for (int i = 0; i < 6; i++) begin
      chk[i] = (^(din & ECC_MASK[i])) ^ fdata[32+i];
    end
    chk[6] = ^fdata;
    res.data   = din;
    res.sb_err = chk[6];
    res.db_err = (chk[5:0] != 6'd0) && !chk[6];
    // A syndrome that names a check-bit position leaves the data untouched.
    for (int j = 0; j < 32; j++) begin
      for (int k = 0; k < 6; k++) begin
        pos[k] = ECC_MASK[k][j];
      end
      if (chk[6] && (pos == chk[5:0])) begin
        res.data[j] = ~din[j];
      end else begin
        res.data[j] = din[j];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/eh2_lsu_rmw_merge.sv
// Combinational datapath: correct the DCCM read word, overlay store bytes, re-encode.
module eh2_lsu_rmw_merge
  import eh2_pkg::*;
(
  input  logic [38:0] rd_fdata,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_byteen,
  output logic [38:0] merged_fdata,
  output logic        sb_err,
  output logic        db_err
);

  ecc_dec_t    dec_s;
  logic [31:0] merged_s;

  // Decode the read word and pick each byte lane from store or memory.
  always_comb begin
    dec_s    = rvecc_decode(rd_fdata);
    merged_s = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (st_byteen[k]) begin
        merged_s[8*k +: 8] = st_data[8*k +: 8];
      end else begin
        merged_s[8*k +: 8] = dec_s.data[8*k +: 8];
      end
    end
    merged_fdata = {rvecc_encode(merged_s), merged_s};
    sb_err       = dec_s.sb_err;
    db_err       = dec_s.db_err;
  end

endmodule

// File: rtl/eh2_lsu_dccm_rmw.sv
// Store sequencer in front of the DCCM: full words are written directly, sub-word
// stores go through read, correct, merge and write-back.
module eh2_lsu_dccm_rmw
  import eh2_pkg::*;
#(
  parameter int DCCM_BITS         = 16,
  parameter int DATA_WIDTH        = 32,
  parameter int ECC_WIDTH         = 7,
  parameter int FDATA_WIDTH       = 39,
  parameter int LOAD_TO_USE_PLUS1 = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [DCCM_BITS-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]  st_data,
  input  logic [3:0]             st_byteen,
  input  logic                   port_blocked,
  output logic                   dccm_wren,
  output logic                   dccm_rden,
  output logic [DCCM_BITS-1:0]   dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]   dccm_wr_addr_hi,
  output logic [DCCM_BITS-1:0]   dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]   dccm_rd_addr_hi,
  output logic [FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [FDATA_WIDTH-1:0] dccm_wr_data_hi,
  input  logic [FDATA_WIDTH-1:0] dccm_rd_data_lo,
  output logic                   pend_valid,
  output logic [DCCM_BITS-3:0]   pend_addr,
  output logic                   rmw_sb_err,
  output logic                   rmw_db_err
);

  rmw_state_e             state_r, state_s;
  logic [DCCM_BITS-3:0]   addr_r;
  logic [DATA_WIDTH-1:0]  data_r;
  logic [3:0]             byteen_r;
  logic [FDATA_WIDTH-1:0] wr_data_r, wr_data_s, merged_fdata_s;
  logic [ECC_WIDTH-1:0]   st_ecc_s;
  logic pend_valid_r, pend_valid_s, sb_err_r, sb_err_s, db_err_r, db_err_s;
  logic wait_cnt_r, wait_cnt_s, wait_last_s, latch_s, rden_s, wren_s, go_s;
  logic merge_sb_s, merge_db_s, unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^st_addr[1:0];
  assign st_ecc_s          = rvecc_encode(st_data);
  // A port access is only legal when the load pipe is off the port and not in reset.
  assign go_s              = !port_blocked && !rst;
  assign wait_last_s       = (LOAD_TO_USE_PLUS1 == 0) ? 1'b1 : wait_cnt_r;

  eh2_lsu_rmw_merge u_merge (
    .rd_fdata     (dccm_rd_data_lo),
    .st_data      (data_r),
    .st_byteen    (byteen_r),
    .merged_fdata (merged_fdata_s),
    .sb_err       (merge_sb_s),
    .db_err       (merge_db_s)
  );

  // Next-state, port strobes and register updates.
  always_comb begin
    state_s      = state_r;
    wr_data_s    = wr_data_r;
    pend_valid_s = pend_valid_r;
    sb_err_s     = 1'b0;
    db_err_s     = 1'b0;
    wait_cnt_s   = 1'b0;
    latch_s      = 1'b0;
    rden_s       = 1'b0;
    wren_s       = 1'b0;
    case (state_r)
      RMW_IDLE: begin
        if (st_valid) begin
          latch_s      = 1'b1;
          pend_valid_s = 1'b1;
          if (st_byteen == 4'hF) begin
            wr_data_s = {st_ecc_s, st_data};
            state_s   = RMW_WR;
          end else begin
            state_s   = RMW_RD;
          end
        end else begin
          state_s = RMW_IDLE;
        end
      end
      RMW_RD: begin
        if (go_s) begin
          rden_s  = 1'b1;
          state_s = RMW_WAIT;
        end else begin
          state_s = RMW_RD;
        end
      end
      RMW_WAIT: begin
        if (!wait_last_s) begin
          wait_cnt_s = 1'b1;
        end else if (merge_db_s) begin
          db_err_s     = 1'b1;
          pend_valid_s = 1'b0;
          state_s      = RMW_IDLE;
        end else begin
          sb_err_s  = merge_sb_s;
          wr_data_s = merged_fdata_s;
          state_s   = RMW_WR;
        end
      end
      RMW_WR: begin
        if (go_s) begin
          wren_s       = 1'b1;
          pend_valid_s = 1'b0;
          state_s      = RMW_IDLE;
        end else begin
          state_s = RMW_WR;
        end
      end
      default: begin
        pend_valid_s = 1'b0;
        state_s      = RMW_IDLE;
      end
    endcase
  end

  // Sequencer state, latched request and write-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RMW_IDLE;
      addr_r       <= '0;
      data_r       <= '0;
      byteen_r     <= 4'd0;
      wr_data_r    <= '0;
      pend_valid_r <= 1'b0;
      sb_err_r     <= 1'b0;
      db_err_r     <= 1'b0;
      wait_cnt_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_data_r    <= wr_data_s;
      pend_valid_r <= pend_valid_s;
      sb_err_r     <= sb_err_s;
      db_err_r     <= db_err_s;
      wait_cnt_r   <= wait_cnt_s;
      if (latch_s) begin
        addr_r   <= st_addr[DCCM_BITS-1:2];
        data_r   <= st_data;
        byteen_r <= st_byteen;
      end
    end
  end

  assign st_ready        = (state_r == RMW_IDLE);
  assign dccm_rden       = rden_s;
  assign dccm_wren       = wren_s;
  assign dccm_rd_addr_lo = {addr_r, 2'b00};
  assign dccm_rd_addr_hi = {addr_r, 2'b00};
  assign dccm_wr_addr_lo = {addr_r, 2'b00};
  assign dccm_wr_addr_hi = {addr_r, 2'b00};
  assign dccm_wr_data_lo = wr_data_r;
  assign dccm_wr_data_hi = wr_data_r;
  assign pend_valid      = pend_valid_r;
  assign pend_addr       = addr_r;
  assign rmw_sb_err      = sb_err_r;
  assign rmw_db_err      = db_err_r;

endmodule
